registers_bank_controller: RTL and testbench
============================================

Name: registers_bank_controller

Overview:
- Parametrised Avalon-MM register slave for the loopback datapath.
- Counts per-channel message-arrival strobes in NUM_CH counters and provides a scratch/debug register, a control register and sticky overflow status.
- Generalises the single-counter controller with:
  - multiple channels;
  - configurable counter width;
  - wrap or saturate mode;
  - clear-on-read;
  - a bulk-clear register;
  - address-window decoding so several instances can share one bus.

Parameters:
- ADDR_BASE, 0: word address of register 0 on the shared bus.
- NUM_CH, 4: number of counter channels, 1..16.
- CNT_W, 32: counter width, 1..DATA_W.
- DATA_W, 32: Avalon data width.
- SATURATE, 0: 0 = counters wrap at max; 1 = counters hold at max.
- VERSION, 32'h0001_0000: constant returned by the ID register.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- msg_enter  in  NUM_CH  per-channel level strobe; +1 on every clk where high.
- reg_mm  avalon_mm_if slave  -  uses address, read, write, writedata (DATA_W), readdata (DATA_W), readdatavalid.

Behaviour:
- Reset: clk is the only clock; rst_n is synchronous and active-low. Reset values:
  - readdata = 0, readdatavalid = 0;
  - all counters = 0;
  - CTRL = 0x1 (enable = 1, clear-on-read = 0);
  - SCRATCH = 0;
  - OVF = 0.
- Decode: off = address - ADDR_BASE. The access is in-window when address >= ADDR_BASE and off < 0x10 + NUM_CH.
- Out-of-window access: writes ignored, no read response (readdatavalid stays 0).
- Register map (word offsets):
  - 0x0 ID: RO, returns VERSION.
  - 0x1 CTRL: RW. bit0 EN (counting enable); bit1 COR (clear-on-read). Other bits read 0.
  - 0x2 SCRATCH: RW, full DATA_W, no side effects.
  - 0x3 CLEAR: WO. Writing bit i = 1 zeroes counter i next cycle; reads return 0.
  - 0x4 OVF: RO / write-1-to-clear. Bit i is sticky, set when counter i wraps or saturates.
  - 0x10+i CNT[i]: RO, zero-extended from CNT_W to DATA_W.
  - Unmapped in-window offsets: read 0, writes ignored. Writes to RO registers ignored.
- Read timing:
  - Fixed latency 1: a read sampled at edge N gives readdatavalid = 1 with readdata at edge N+1, for exactly one cycle.
  - Back-to-back reads are allowed, one response per cycle.
  - readdata returns to 0 when readdatavalid = 0.
- Write timing: takes effect at the sampling edge; visible to a read issued the following cycle.
- Read and write in the same cycle: the write is applied; the read returns the pre-write value.
- Counter update for channel i, per cycle, highest priority first:
  1. rst_n = 0 -> 0.
  2. CLEAR bit i written -> 0 (clear beats an increment).
  3. COR = 1 and CNT[i] read this cycle -> value becomes msg_enter[i]&EN; the read returns the old value.
  4. msg_enter[i] & EN -> +1.
- Overflow at 2^CNT_W-1 with an increment:
  - SATURATE = 0: wraps to 0 and sets OVF[i].
  - SATURATE = 1: holds at max and sets OVF[i] on every attempt.
- OVF set and W1C in the same cycle: set wins.
- EN = 0 freezes all counters; reads and clears still work.
- Reset mid-read: the pending response is dropped (readdatavalid = 0 in the next cycle).

Decomposition:
- registers_bank_pkg holds:
  - offset localparams: OFF_ID, OFF_CTRL, OFF_SCRATCH, OFF_CLEAR, OFF_OVF, OFF_CNT_BASE;
  - CTRL bit indices: CTRL_EN, CTRL_COR;
  - UNMAPPED_RDATA = 0.
- Sub-module msg_channel_counter (params CNT_W, SATURATE):
  - inputs: inc, clr, cor_rd;
  - outputs: count, ovf_pulse.
- The top level instantiates NUM_CH copies via generate and owns decode, CTRL, SCRATCH, OVF and the read pipeline.

Test Plan:
- Reset, then read offsets 0x0, 0x1, 0x2, 0x4, 0x10 -> 32'h0001_0000, 0x1, 0, 0, 0, each with readdatavalid exactly one cycle after read.
- Write SCRATCH = 32'hDEADBEEF, read next cycle -> DEADBEEF. Same-cycle write 0x12345678 + read -> read returns DEADBEEF, the following read returns 0x12345678.
- msg_enter[2] high for 10 cycles, then read 0x12 -> 10. Read 0x10 -> 0.
- Set COR: msg_enter[0] high 5 cycles then low, read 0x10 twice -> 5 then 0. With msg_enter[0] held high during the read -> old value returned, counter = 1 next cycle.
- CNT_W = 4:
  - SATURATE = 0, 17 strobes -> CNT = 1, OVF bit0 = 1; W1C 0x1 -> OVF = 0.
  - SATURATE = 1 -> CNT = 15, OVF bit0 = 1.
- ADDR_BASE = 0x40:
  - read 0x00 -> no readdatavalid;
  - write to 0x3F ignored;
  - CLEAR write 0x4 with simultaneous msg_enter[2] -> CNT[2] = 0.

Source files
------------

// File: rtl/registers_bank_controller_pkg.sv
// Shared register-map offsets and CTRL bit positions for the message-counter
// register bank.
package registers_bank_pkg;

  localparam int unsigned OFF_ID       = 32'd0;
  localparam int unsigned OFF_CTRL     = 32'd1;
  localparam int unsigned OFF_SCRATCH  = 32'd2;
  localparam int unsigned OFF_CLEAR    = 32'd3;
  localparam int unsigned OFF_OVF      = 32'd4;
  localparam int unsigned OFF_CNT_BASE = 32'd16;

  localparam int CTRL_EN  = 32'd0;
  localparam int CTRL_COR = 32'd1;

  localparam logic [1:0]  CTRL_RESET     = 2'b01;
  localparam logic [31:0] UNMAPPED_RDATA = 32'd0;

endpackage

// File: rtl/registers_bank_controller_if.sv
// Avalon-MM register-bus bundle: fixed read latency of one cycle, no waitrequest.
interface avalon_mm_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) ();

  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata, readdatavalid
  );

endinterface

// File: rtl/registers_bank_controller_msg_channel_counter.sv
// One message-arrival counter: clear beats clear-on-read, which beats increment;
// wraps or saturates at all-ones and flags the event with ovf_pulse.
module msg_channel_counter #(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  input  logic             cor_rd,
  output logic [CNT_W-1:0] count,
  output logic             ovf_pulse
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] next_s;
  logic             at_max_s;

  // Next-count selection and overflow detection
  always_comb begin
    at_max_s  = (count_r == CNT_MAX);
    ovf_pulse = inc & ~clr & ~cor_rd & at_max_s;
    if (clr) begin
      next_s = '0;
    end else if (cor_rd) begin
      // A read that clears still counts an arrival seen in the same cycle
      next_s = CNT_W'(inc);
    end else if (inc) begin
      if (at_max_s) begin
        next_s = (SATURATE != 32'd0) ? CNT_MAX : '0;
      end else begin
        next_s = count_r + CNT_W'(1'b1);
      end
    end else begin
      next_s = count_r;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r <= '0;
    end else begin
      count_r <= next_s;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/registers_bank_controller.sv
// Avalon-MM register slave: per-channel arrival counters plus ID, CTRL, SCRATCH,
// bulk CLEAR and sticky OVF registers behind a relocatable address window.
module registers_bank_controller
  import registers_bank_pkg::*;
#(
  parameter int unsigned ADDR_BASE = 32'd0,
  parameter int unsigned NUM_CH    = 32'd4,
  parameter int unsigned CNT_W     = 32'd32,
  parameter int unsigned DATA_W    = 32'd32,
  parameter int unsigned SATURATE  = 32'd0,
  parameter logic [31:0] VERSION   = 32'h0001_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] msg_enter,
  avalon_mm_if.slave        reg_mm
);

  logic [31:0]       addr_s;
  logic [31:0]       off_s;
  logic              in_win_s;
  logic              rd_s;
  logic              wr_s;
  logic [1:0]        ctrl_r;
  logic [DATA_W-1:0] scratch_r;
  logic [DATA_W-1:0] rdata_r;
  logic [DATA_W-1:0] rmux_s;
  logic              rvalid_r;
  logic [NUM_CH-1:0] ovf_r;
  logic [NUM_CH-1:0] ovf_pulse_s;
  logic [NUM_CH-1:0] clr_s;
  logic [NUM_CH-1:0] w1c_s;
  logic [NUM_CH-1:0] cor_rd_s;
  logic [NUM_CH-1:0] inc_s;
  logic [CNT_W-1:0]  cnt_s [NUM_CH];

  // Window decode and per-channel strobes
  always_comb begin
    addr_s   = 32'(reg_mm.address);
    off_s    = addr_s - ADDR_BASE;
    in_win_s = (addr_s >= ADDR_BASE) && (off_s < (OFF_CNT_BASE + NUM_CH));
    rd_s     = reg_mm.read  & in_win_s;
    wr_s     = reg_mm.write & in_win_s;
    if (wr_s && (off_s == OFF_CLEAR)) begin
      clr_s = reg_mm.writedata[NUM_CH-1:0];
    end else begin
      clr_s = '0;
    end
    if (wr_s && (off_s == OFF_OVF)) begin
      w1c_s = reg_mm.writedata[NUM_CH-1:0];
    end else begin
      w1c_s = '0;
    end
    inc_s = msg_enter & {NUM_CH{ctrl_r[CTRL_EN]}};
    for (int i = 0; i < NUM_CH; i++) begin
      cor_rd_s[i] = rd_s & ctrl_r[CTRL_COR] & (off_s == (OFF_CNT_BASE + 32'(i)));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    msg_channel_counter #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) u_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (inc_s[g]),
      .clr       (clr_s[g]),
      .cor_rd    (cor_rd_s[g]),
      .count     (cnt_s[g]),
      .ovf_pulse (ovf_pulse_s[g])
    );
  end

  // Read-data multiplexer, sampled from pre-write register state
  always_comb begin
    rmux_s = DATA_W'(UNMAPPED_RDATA);
    case (off_s)
      OFF_ID:      rmux_s = DATA_W'(VERSION);
      OFF_CTRL:    rmux_s = DATA_W'(ctrl_r);
      OFF_SCRATCH: rmux_s = scratch_r;
      OFF_CLEAR:   rmux_s = DATA_W'(UNMAPPED_RDATA);
      OFF_OVF:     rmux_s = DATA_W'(ovf_r);
      default: begin
        for (int i = 0; i < NUM_CH; i++) begin
          rmux_s = (off_s == (OFF_CNT_BASE + 32'(i))) ? DATA_W'(cnt_s[i]) : rmux_s;
        end
      end
    endcase
  end

  // Control/status registers and the one-cycle read response pipeline
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_r    <= CTRL_RESET;
      scratch_r <= '0;
      ovf_r     <= '0;
      rdata_r   <= '0;
      rvalid_r  <= 1'b0;
    end else begin
      rvalid_r <= rd_s;
      rdata_r  <= rd_s ? rmux_s : '0;
      if (wr_s && (off_s == OFF_CTRL)) begin
        ctrl_r <= reg_mm.writedata[1:0];
      end
      if (wr_s && (off_s == OFF_SCRATCH)) begin
        scratch_r <= reg_mm.writedata;
      end
      // A new overflow wins over a simultaneous write-1-to-clear
      ovf_r <= (ovf_r & ~w1c_s) | ovf_pulse_s;
    end
  end

  assign reg_mm.readdata      = rdata_r;
  assign reg_mm.readdatavalid = rvalid_r;

endmodule

// File: tb/tb_registers_bank_controller.sv
// Directed plus randomized checks of three register-bank configurations against
// a behavioural register-map model.
module tb_registers_bank_controller;

  logic       clk;
  logic       rst_n;
  logic [3:0] me0, me1, me2;
  int         n_assert = 0;
  int         n_fail   = 0;

  avalon_mm_if #(.ADDR_W(16), .DATA_W(32)) bus0 ();
  avalon_mm_if #(.ADDR_W(16), .DATA_W(32)) bus1 ();
  avalon_mm_if #(.ADDR_W(16), .DATA_W(32)) bus2 ();

  registers_bank_controller #(.ADDR_BASE(0), .NUM_CH(4), .CNT_W(32), .DATA_W(32), .SATURATE(0))
    dut0 (.clk(clk), .rst_n(rst_n), .msg_enter(me0), .reg_mm(bus0));
  registers_bank_controller #(.ADDR_BASE(0), .NUM_CH(4), .CNT_W(4), .DATA_W(32), .SATURATE(0))
    dut1 (.clk(clk), .rst_n(rst_n), .msg_enter(me1), .reg_mm(bus1));
  registers_bank_controller #(.ADDR_BASE(32'h40), .NUM_CH(4), .CNT_W(4), .DATA_W(32), .SATURATE(1))
    dut2 (.clk(clk), .rst_n(rst_n), .msg_enter(me2), .reg_mm(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Reference model state, one slot per DUT
  int          cw_a   [3] = '{32, 4, 4};
  int          sat_a  [3] = '{0, 0, 1};
  int          base_a [3] = '{0, 0, 64};
  longint      m_cnt  [3][4];
  logic [1:0]  m_ctrl [3];
  logic [31:0] m_scr  [3];
  logic [3:0]  m_ovf  [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 4; i++) m_cnt[d][i] = 0;
      m_ctrl[d] = 2'b01;
      m_scr[d]  = 32'd0;
      m_ovf[d]  = 4'd0;
    end
  endtask

  function automatic bit in_win(input int d, input int addr);
    return (addr >= base_a[d]) && ((addr - base_a[d]) < 20);
  endfunction

  function automatic logic [31:0] mread(input int d, input int addr);
    int off = addr - base_a[d];
    if (off == 0) return 32'h0001_0000;
    if (off == 1) return {30'd0, m_ctrl[d]};
    if (off == 2) return m_scr[d];
    if (off == 4) return {28'd0, m_ovf[d]};
    if (off >= 16 && off < 20) return m_cnt[d][off-16][31:0];
    return 32'd0;
  endfunction

  task automatic model_update(input int d, input logic rd, input logic wr, input int addr,
                              input logic [31:0] wd, input logic [3:0] me);
    int         off = addr - base_a[d];
    bit         inw = in_win(d, addr);
    logic       en  = m_ctrl[d][0];
    logic       cor = m_ctrl[d][1];
    logic [3:0] clr = 4'd0;
    logic [3:0] w1c = 4'd0;
    logic [3:0] set = 4'd0;
    longint     mx  = (64'd1 << cw_a[d]) - 1;
    if (wr && inw) begin
      if (off == 1) m_ctrl[d] = wd[1:0];
      if (off == 2) m_scr[d]  = wd;
      if (off == 3) clr = wd[3:0];
      if (off == 4) w1c = wd[3:0];
    end
    for (int i = 0; i < 4; i++) begin
      if (clr[i]) m_cnt[d][i] = 0;
      else if (rd && inw && cor && off == 16 + i) m_cnt[d][i] = (me[i] && en) ? 1 : 0;
      else if (me[i] && en) begin
        if (m_cnt[d][i] == mx) begin
          set[i] = 1'b1;
          m_cnt[d][i] = (sat_a[d] != 0) ? mx : 0;
        end else m_cnt[d][i] = m_cnt[d][i] + 1;
      end
    end
    m_ovf[d] = (m_ovf[d] & ~w1c) | set;
  endtask

  task automatic drive(input int d, input logic rd, input logic wr, input int addr,
                       input logic [31:0] wd, input logic [3:0] me);
    bus0.read = 1'b0; bus0.write = 1'b0; bus0.address = 16'd0; bus0.writedata = 32'd0;
    bus1.read = 1'b0; bus1.write = 1'b0; bus1.address = 16'd0; bus1.writedata = 32'd0;
    bus2.read = 1'b0; bus2.write = 1'b0; bus2.address = 16'd0; bus2.writedata = 32'd0;
    me0 = 4'd0; me1 = 4'd0; me2 = 4'd0;
    case (d)
      0: begin bus0.read = rd; bus0.write = wr; bus0.address = 16'(addr); bus0.writedata = wd; me0 = me; end
      1: begin bus1.read = rd; bus1.write = wr; bus1.address = 16'(addr); bus1.writedata = wd; me1 = me; end
      2: begin bus2.read = rd; bus2.write = wr; bus2.address = 16'(addr); bus2.writedata = wd; me2 = me; end
      default: ;
    endcase
  endtask

  // One bus cycle on DUT d; checks the response against the model
  task automatic step(input int d, input logic rd, input logic wr, input int addr,
                      input logic [31:0] wd, input logic [3:0] me, input string tag,
                      output logic obs_v, output logic [31:0] obs_d);
    logic        exp_v = rd && in_win(d, addr);
    logic [31:0] exp_d = exp_v ? mread(d, addr) : 32'd0;
    drive(d, rd, wr, addr, wd, me);
    @(posedge clk);
    model_update(d, rd, wr, addr, wd, me);
    #1;
    case (d)
      0: begin obs_v = bus0.readdatavalid; obs_d = bus0.readdata; end
      1: begin obs_v = bus1.readdatavalid; obs_d = bus1.readdata; end
      default: begin obs_v = bus2.readdatavalid; obs_d = bus2.readdata; end
    endcase
    chk({tag, "_valid"}, 32'(obs_v), 32'(exp_v));
    chk({tag, "_data"}, obs_d, exp_d);
  endtask

  logic        v;
  logic [31:0] o;

  initial begin
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 0, 32'd0, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid0", 32'(bus0.readdatavalid), 32'd0);
    chk("rst_data0", bus0.readdata, 32'd0);
    chk("rst_valid2", 32'(bus2.readdatavalid), 32'd0);
    model_reset();
    rst_n = 1'b1;

    // Reset values through the bus
    step(0, 1'b1, 1'b0, 0,  32'd0, 4'd0, "id", v, o);      chk("id_const", o, 32'h0001_0000);
    chk("id_latency", 32'(v), 32'd1);
    step(0, 1'b1, 1'b0, 1,  32'd0, 4'd0, "ctrl", v, o);    chk("ctrl_const", o, 32'h1);
    step(0, 1'b1, 1'b0, 2,  32'd0, 4'd0, "scr", v, o);     chk("scr_const", o, 32'h0);
    step(0, 1'b1, 1'b0, 4,  32'd0, 4'd0, "ovf", v, o);     chk("ovf_const", o, 32'h0);
    step(0, 1'b1, 1'b0, 16, 32'd0, 4'd0, "cnt0", v, o);    chk("cnt0_const", o, 32'h0);
    step(0, 1'b0, 1'b0, 0,  32'd0, 4'd0, "idle", v, o);    chk("single_pulse", 32'(v), 32'd0);

    // SCRATCH write/read and same-cycle read+write
    step(0, 1'b0, 1'b1, 2, 32'hDEADBEEF, 4'd0, "scr_wr", v, o);
    step(0, 1'b1, 1'b0, 2, 32'd0, 4'd0, "scr_rd", v, o);            chk("scr_db", o, 32'hDEADBEEF);
    step(0, 1'b1, 1'b1, 2, 32'h12345678, 4'd0, "scr_rw", v, o);     chk("scr_prewrite", o, 32'hDEADBEEF);
    step(0, 1'b1, 1'b0, 2, 32'd0, 4'd0, "scr_rd2", v, o);           chk("scr_new", o, 32'h12345678);

    // Channel 2 counting
    for (int k = 0; k < 10; k++) step(0, 1'b0, 1'b0, 0, 32'd0, 4'b0100, "strobe2", v, o);
    step(0, 1'b1, 1'b0, 18, 32'd0, 4'd0, "cnt2", v, o);   chk("cnt2_ten", o, 32'd10);
    step(0, 1'b1, 1'b0, 16, 32'd0, 4'd0, "cnt0b", v, o);  chk("cnt0_zero", o, 32'd0);

    // Clear-on-read
    step(0, 1'b0, 1'b1, 1, 32'h3, 4'd0, "cor_en", v, o);
    for (int k = 0; k < 5; k++) step(0, 1'b0, 1'b0, 0, 32'd0, 4'b0001, "strobe0", v, o);
    step(0, 1'b1, 1'b0, 16, 32'd0, 4'd0, "cor1", v, o);   chk("cor_five", o, 32'd5);
    step(0, 1'b1, 1'b0, 16, 32'd0, 4'd0, "cor2", v, o);   chk("cor_cleared", o, 32'd0);
    for (int k = 0; k < 3; k++) step(0, 1'b0, 1'b0, 0, 32'd0, 4'b0001, "strobe0", v, o);
    step(0, 1'b1, 1'b0, 16, 32'd0, 4'b0001, "cor3", v, o); chk("cor_old", o, 32'd3);
    step(0, 1'b1, 1'b0, 16, 32'd0, 4'd0, "cor4", v, o);    chk("cor_one", o, 32'd1);
    step(0, 1'b0, 1'b1, 1, 32'h1, 4'd0, "cor_dis", v, o);

    // 4-bit wrapping counter and OVF W1C
    for (int k = 0; k < 17; k++) step(1, 1'b0, 1'b0, 0, 32'd0, 4'b0001, "wrap_s", v, o);
    step(1, 1'b1, 1'b0, 16, 32'd0, 4'd0, "wrap_cnt", v, o); chk("wrap_one", o, 32'd1);
    step(1, 1'b1, 1'b0, 4, 32'd0, 4'd0, "wrap_ovf", v, o);  chk("wrap_ovf_set", o, 32'd1);
    step(1, 1'b0, 1'b1, 4, 32'h1, 4'd0, "w1c", v, o);
    step(1, 1'b1, 1'b0, 4, 32'd0, 4'd0, "w1c_rd", v, o);    chk("ovf_w1c", o, 32'd0);

    // Saturating counter behind base 0x40
    for (int k = 0; k < 17; k++) step(2, 1'b0, 1'b0, 64, 32'd0, 4'b0001, "sat_s", v, o);
    step(2, 1'b1, 1'b0, 80, 32'd0, 4'd0, "sat_cnt", v, o);  chk("sat_max", o, 32'd15);
    step(2, 1'b1, 1'b0, 68, 32'd0, 4'd0, "sat_ovf", v, o);  chk("sat_ovf_set", o, 32'd1);
    step(2, 1'b1, 1'b0, 0, 32'd0, 4'd0, "outwin", v, o);    chk("outwin_novalid", 32'(v), 32'd0);
    step(2, 1'b0, 1'b1, 63, 32'hFFFFFFFF, 4'd0, "wr3f", v, o);
    step(2, 1'b1, 1'b0, 66, 32'd0, 4'd0, "scr_b", v, o);    chk("wr3f_ignored", o, 32'd0);
    step(2, 1'b1, 1'b0, 65, 32'd0, 4'd0, "ctrl_b", v, o);   chk("wr3f_ctrl", o, 32'd1);
    for (int k = 0; k < 3; k++) step(2, 1'b0, 1'b0, 64, 32'd0, 4'b0100, "clr_s", v, o);
    step(2, 1'b0, 1'b1, 67, 32'h4, 4'b0100, "clr_wr", v, o);
    step(2, 1'b1, 1'b0, 82, 32'd0, 4'd0, "clr_rd", v, o);   chk("clear_beats_inc", o, 32'd0);

    // Reset while a read is pending
    drive(0, 1'b1, 1'b0, 0, 32'd0, 4'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_midread", 32'(bus0.readdatavalid), 32'd0);
    rst_n = 1'b1;
    model_reset();

    // Randomized traffic against the model
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 150; k++) begin
        int   a;
        logic rd = 1'($urandom % 2);
        logic wr = (($urandom % 4) == 0);
        if (($urandom % 8) == 0) a = int'($urandom % 128);
        else a = base_a[d] + int'($urandom % 21);
        step(d, rd, wr, a, $urandom, 4'($urandom), "rand", v, o);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
